// File: rtl/event_sram_if.sv
// Port bundle for event_sram: write/read request lines, read return, clear control and FSM visibility.
interface event_sram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 3
);
  // Handshake: there is no ready. A request is taken on a rising edge only while busy is low
  // and clear is low. rd_valid is a one-cycle qualifier for a new d_out value.
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic                  sense_en;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  rd_valid;
  logic                  clear;
  logic                  busy;
  logic [0:0]            state;

  modport master (
    output wr_en, wr_addr, d_in, sense_en, rd_addr, clear,
    input  d_out, rd_valid, busy, state
  );

  modport slave (
    input  wr_en, wr_addr, d_in, sense_en, rd_addr, clear,
    output d_out, rd_valid, busy, state
  );
endinterface

// File: rtl/event_sram.sv
// Simple-dual-port event store with 1/2-cycle read latency, collision mode select and a zeroing sweep.
module event_sram #(
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 8,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic         clk,
  input logic         rst,
  event_sram_if.slave bus
);
  localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0]    IDLE        = 1'b0;
  localparam logic [0:0]    CLEAR       = 1'b1;
  localparam logic [0:0]    RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  localparam logic [AW:0]   DEPTH_L     = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("event_sram: READ_LATENCY must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("event_sram: DEPTH must be at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic [AW-1:0]         clr_addr;
  logic                  busy_q;
  logic                  idle_go;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] d_out_q;
  logic                  rd_valid_q;

  assign idle_go     = (state == IDLE) && !bus.clear;
  assign wr_ok       = idle_go && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_L);
  assign rd_ok       = idle_go && bus.sense_en;
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);

  // Out-of-range reads still answer, with zero data.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (WRITE_FIRST != 0 && wr_ok && bus.wr_addr == bus.rd_addr) begin
        rd_word = bus.d_in;
      end else begin
        rd_word = mem[bus.rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_STATE;
      clr_addr <= '0;
      busy_q   <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        default: begin
          if (bus.clear) begin
            state    <= CLEAR;
            busy_q   <= 1'b1;
            clr_addr <= '0;
          end
        end
      endcase
    end
  end

  // Storage has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.d_in;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid   <= 1'b0;
        s1_data    <= '0;
        rd_valid_q <= 1'b0;
        d_out_q    <= '0;
      end else begin
        s1_valid   <= rd_ok;
        rd_valid_q <= s1_valid;
        if (rd_ok) s1_data <= rd_word;
        if (s1_valid) d_out_q <= s1_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid_q <= 1'b0;
        d_out_q    <= '0;
      end else begin
        rd_valid_q <= rd_ok;
        if (rd_ok) d_out_q <= rd_word;
      end
    end
  end

  assign bus.d_out    = d_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.state    = state;
endmodule

// File: tb/tb_event_sram.sv
// Drives four event_sram configurations with one directed stimulus stream and scores each separately.
module tb_event_sram;
  localparam int DW = 16;
  localparam int AW = 3;

  // Instance order: 0 = lat1/old-data, 1 = lat2/new-data, 2 = no reset sweep, 3 = depth 6 lat2
  int lat[4] = '{1, 2, 1, 2};
  int dep[4] = '{8, 8, 8, 6};

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en = 1'b0, sense_en = 1'b0, clear = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] d_in = '0;

  logic [DW-1:0] dout [4];
  logic [3:0]    vld, bsy;
  logic [0:0]    st [4];

  logic [DW-1:0] exp_q [4][$];
  int            due_q [4][$];
  logic [DW-1:0] last [4];
  int            edge_cnt = 0;
  int            n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  event_sram_if #(.DATA_WIDTH(DW), .AW(AW)) bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_conn
    assign bus[g].wr_en    = wr_en;
    assign bus[g].wr_addr  = wr_addr;
    assign bus[g].d_in     = d_in;
    assign bus[g].sense_en = sense_en;
    assign bus[g].rd_addr  = rd_addr;
    assign bus[g].clear    = clear;
    assign dout[g]         = bus[g].d_out;
    assign vld[g]          = bus[g].rd_valid;
    assign bsy[g]          = bus[g].busy;
    assign st[g]           = bus[g].state;
  end

  event_sram #(.DATA_WIDTH(DW), .DEPTH(8), .READ_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1))
    u_lat1 (.clk(clk), .rst(rst), .bus(bus[0]));
  event_sram #(.DATA_WIDTH(DW), .DEPTH(8), .READ_LATENCY(2), .WRITE_FIRST(1), .CLEAR_ON_RESET(1))
    u_lat2_wf (.clk(clk), .rst(rst), .bus(bus[1]));
  event_sram #(.DATA_WIDTH(DW), .DEPTH(8), .READ_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(0))
    u_nocor (.clk(clk), .rst(rst), .bus(bus[2]));
  event_sram #(.DATA_WIDTH(DW), .DEPTH(6), .READ_LATENCY(2), .WRITE_FIRST(0), .CLEAR_ON_RESET(1))
    u_d6 (.clk(clk), .rst(rst), .bus(bus[3]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard: every rd_valid pops one expected word and its due edge; otherwise d_out must hold.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    int            due;
    for (int g = 0; g < 4; g++) begin
      if (rst) begin
        last[g] = '0;
      end else if (vld[g]) begin
        if (exp_q[g].size() == 0) begin
          check_val($sformatf("spurious_rd_valid[%0d]", g), 32'(vld[g]), 32'(0));
        end else begin
          e   = exp_q[g].pop_front();
          due = due_q[g].pop_front();
          check_val($sformatf("rd_data[%0d]", g), 32'(dout[g]), 32'(e));
          check_val($sformatf("rd_edge[%0d]", g), 32'(edge_cnt), 32'(due));
          last[g] = e;
        end
      end else begin
        check_val($sformatf("d_out_hold[%0d]", g), 32'(dout[g]), 32'(last[g]));
      end
    end
  end

  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic re, input logic [AW-1:0] ra, input logic clr,
                      input logic [3:0] acc, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                      input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    logic [DW-1:0] e [4];
    e = '{e0, e1, e2, e3};
    @(negedge clk);
    wr_en = we; wr_addr = wa; d_in = wd;
    sense_en = re; rd_addr = ra; clear = clr;
    for (int g = 0; g < 4; g++) begin
      if (acc[g]) begin
        exp_q[g].push_back(e[g]);
        due_q[g].push_back(edge_cnt + lat[g]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, '0, 1'b0, 4'b0000, '0, '0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b1, a, d, 1'b0, '0, 1'b0, 4'b0000, '0, '0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                    input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    step(1'b0, '0, '0, 1'b1, a, 1'b0, 4'b1111, e0, e1, e2, e3);
  endtask

  task automatic rd_all(input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd(a, e, e, e, e);
  endtask

  // Called just after an edge; the reset edge is asynchronous and lands mid high phase.
  task automatic pulse_rst(input int n, input logic [3:0] want_busy);
    #1 rst = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      check_val($sformatf("rst_busy[%0d]", g), 32'(bsy[g]), 32'(want_busy[g]));
      check_val($sformatf("rst_valid[%0d]", g), 32'(vld[g]), 32'(0));
      check_val($sformatf("rst_dout[%0d]", g), 32'(dout[g]), 32'(0));
    end
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // mode 1: busy-time write/read of addr 2 at k=1; mode 2: write 0x4242 at k=1, read at k=2 (only the unswept instance takes them)
  task automatic sweep_check(input string tag, input int l0, input int l1, input int l2,
                             input int l3, input int n, input int mode);
    int len [4];
    len = '{l0, l1, l2, l3};
    for (int k = 1; k <= n; k++) begin
      if (mode == 1 && k == 1) step(1'b1, 3'd2, 16'h7777, 1'b1, 3'd2, 1'b0, 4'b0000, '0, '0, '0, '0);
      else if (mode == 2 && k == 1) wr(3'd0, 16'h4242);
      else if (mode == 2 && k == 2) step(1'b0, '0, '0, 1'b1, 3'd0, 1'b0, 4'b0100, '0, '0, 16'h4242, '0);
      else idle(1);
      for (int g = 0; g < 4; g++) begin
        check_val($sformatf("%s_busy[%0d]_k%0d", tag, g, k), 32'(bsy[g]), 32'(k < len[g]));
        check_val($sformatf("%s_state[%0d]_k%0d", tag, g, k), 32'(st[g]), 32'(k < len[g]));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < 4; g++) begin
      check_val($sformatf("init_busy[%0d]", g), 32'(bsy[g]), 32'(g != 2));
      check_val($sformatf("init_valid[%0d]", g), 32'(vld[g]), 32'(0));
      check_val($sformatf("init_dout[%0d]", g), 32'(dout[g]), 32'(0));
    end
    rst = 1'b0;
    sweep_check("boot", 8, 8, 0, 6, 9, 0);

    // Reset-clear of a preloaded array
    for (int a = 0; a < 8; a++) wr(AW'(a), 16'hFFFF);
    pulse_rst(2, 4'b1011);
    sweep_check("rst_clear", 8, 8, 0, 6, 9, 0);
    for (int a = 0; a < 8; a++) rd(AW'(a), 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
    idle(3);

    // Latency and back-to-back reads
    wr(3'd3, 16'h1234);
    for (int a = 0; a < 8; a++) begin
      if (a == 3) rd_all(3'd3, 16'h1234);
      else rd(AW'(a), 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
    end
    idle(3);
    rd_all(3'd3, 16'h1234);
    idle(2);
    rd_all(3'd3, 16'h1234);
    idle(3);

    // Collision and concurrent write/read to different addresses
    wr(3'd5, 16'h00AA);
    step(1'b1, 3'd5, 16'h00BB, 1'b1, 3'd5, 1'b0, 4'b1111, 16'h00AA, 16'h00BB, 16'h00AA, 16'h00AA);
    rd_all(3'd5, 16'h00BB);
    step(1'b1, 3'd4, 16'h0C0C, 1'b1, 3'd3, 1'b0, 4'b1111, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    rd_all(3'd4, 16'h0C0C);
    idle(3);

    // Clear request: in-flight read finishes with old data, busy-time requests dropped
    rd_all(3'd4, 16'h0C0C);
    step(1'b1, 3'd1, 16'h1111, 1'b1, 3'd1, 1'b1, 4'b0000, '0, '0, '0, '0);
    for (int g = 0; g < 4; g++) check_val($sformatf("clr_busy[%0d]", g), 32'(bsy[g]), 32'(1));
    sweep_check("clr", 8, 8, 8, 6, 8, 1);
    rd_all(3'd2, 16'h0000);
    rd_all(3'd1, 16'h0000);
    rd_all(3'd3, 16'h0000);
    rd_all(3'd4, 16'h0000);
    idle(3);

    // Reset at sweep edge 4 restarts the sweep; the no-sweep instance works on the first edge
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 4'b0000, '0, '0, '0, '0);
    idle(3);
    pulse_rst(2, 4'b1011);
    sweep_check("rst_mid", 8, 8, 0, 6, 9, 2);
    rd(3'd0, 16'h0000, 16'h0000, 16'h4242, 16'h0000);
    idle(3);

    // Out-of-range addresses on the depth-6 instance
    wr(3'd6, 16'h5555);
    rd(3'd6, 16'h5555, 16'h5555, 16'h5555, 16'h0000);
    rd_all(3'd7, 16'h0000);
    idle(4);

    for (int g = 0; g < 4; g++) begin
      check_val($sformatf("pending_reads[%0d]", g), 32'(exp_q[g].size()), 32'(0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/event_sram.md
# event_sram

Parametrised simple-dual-port event storage for the DVS-to-RAVENS event queue. It is the successor to the single-port dummy SRAM and has these additions:
- independent write and read addresses;
- configurable read latency (1 or 2 cycles);
- selectable read/write collision mode;
- a built-in clear sequencer that zeroes every word after reset or on request.

The event queue controller instantiates it as backing store; defaults come from `dvs_ravens_pkg`.

## Interface
- `DATA_WIDTH`, default `EVENT_BITS`: word width in bits.
- `DEPTH`, default `EVENT_QUEUE_DEPTH`: number of words, ≥2; need not be a power of two.
- `READ_LATENCY`, default 1: legal values 1 or 2, enforced by elaboration-time assertion.
- `WRITE_FIRST`, default 0: 1 means a same-address same-cycle read returns the new data; 0 means it returns the old data.
- `CLEAR_ON_RESET`, default 1: 1 means a clear sweep starts automatically on reset release.
- Derived `AW = max(1, $clog2(DEPTH))`.

Ports:
- `clk`: in, 1, sole clock; all logic on rising edge.
- `rst`: in, 1, asynchronous active-high reset.
- `wr_en`: in, 1, write request.
- `wr_addr`: in, AW, write address.
- `d_in`: in, DATA_WIDTH, write data.
- `sense_en`: in, 1, read request.
- `rd_addr`: in, AW, read address.
- `d_out`: out, DATA_WIDTH, read data.
- `rd_valid`: out, 1, one-cycle pulse marking new `d_out`.
- `clear`: in, 1, request a full zeroing sweep.
- `busy`: out, 1, sweep in progress; all requests ignored.

## Operation
FSM states are `IDLE` and `CLEAR`. It uses a clear counter `clr_addr` of width AW.

Reset:
- While `rst` is high: `d_out`=0, `rd_valid`=0, and every read pipeline stage is invalid.
- Also while `rst` is high: `clr_addr`=0 and state=`CLEAR` if `CLEAR_ON_RESET`, else `IDLE`. `busy` equals `CLEAR_ON_RESET`.
- Memory contents are not reset asynchronously; only the sweep clears them.
- Reset asserted mid-sweep aborts the sweep and restarts it from 0 on release (if `CLEAR_ON_RESET`).

`CLEAR` state:
- Each edge writes 0 to `clr_addr` and increments it.
- The edge that writes `DEPTH-1` moves to `IDLE`.
- `wr_en`, `sense_en` and `clear` are ignored.

`IDLE` state:
- `clear`=1 moves to `CLEAR` with `clr_addr`=0 on that edge. Any `wr_en`/`sense_en` presented on that same edge is dropped.

Write (`IDLE`, `wr_en`=1, `clear`=0):
- `mem[wr_addr] <= d_in`.
- `wr_addr ≥ DEPTH` is ignored.

Read (`IDLE`, `sense_en`=1, `clear`=0):
- The request is accepted and the address sampled.
- Data appears after `READ_LATENCY` edges with `rd_valid`=1 for one cycle.
- Reads are fully pipelined: one read per cycle is sustained.
- `rd_addr ≥ DEPTH` returns 0 with `rd_valid`=1.

Between reads:
- `d_out` holds its last value; it changes only together with `rd_valid`=1.

Collision (write and read to the same address on the same edge):
- `WRITE_FIRST`=1: `d_out` gets `d_in`.
- `WRITE_FIRST`=0: `d_out` gets the prior contents.
- The memory is updated in both cases.

Reads already accepted before a sweep starts complete normally with their pre-clear data.

`busy` is a registered output, high exactly while state=`CLEAR`.

## Timing
- Edges are numbered 1, 2, … after `rst` release with `CLEAR_ON_RESET`=1.
  - Edge k clears address k-1.
  - `busy` falls after edge `DEPTH`.
  - The first request accepted is at edge `DEPTH+1`.
- `clear` sampled at edge n: `busy` high from after edge n to after edge n+`DEPTH`.
- Read accepted at edge n: `d_out`/`rd_valid` updated at edge n+`READ_LATENCY`-1. Latency 1 means the same edge's registered output; latency 2 adds one output register.
- Write at edge n is visible to a read accepted at edge n+1 in both collision modes.
- Simultaneous `wr_en` and `sense_en` to different addresses: both are performed on the same edge.

## Test plan
Bench parameters: `DEPTH`=8, `DATA_WIDTH`=16, unless stated.

1. Reset-clear: preload mem with 0xFFFF via writes, pulse `rst`, then read all 8 addresses → `busy` high for exactly 8 edges after release; every read returns 0x0000.
2. Latency 1 and latency 2: write 0x1234 at addr 3, then read addr 3 back-to-back with reads of addrs 0–7 → data arrives 1 (resp. 2) edges after acceptance with one `rd_valid` pulse per read; `d_out` holds between reads.
3. Collision: addr 5 holds 0x00AA; same-edge write 0x00BB and read addr 5 → `WRITE_FIRST`=0 gives 0x00AA, `WRITE_FIRST`=1 gives 0x00BB; a subsequent read gives 0x00BB in both modes.
4. Requests during busy: assert `clear`, then during the sweep write 0x7777 at addr 2 and read addr 2 → write dropped, no `rd_valid`; after `busy` falls addr 2 reads 0x0000.
5. Reset mid-sweep and `CLEAR_ON_RESET`=0: assert `rst` at sweep edge 4 → after release `busy` is high for 8 more edges. With `CLEAR_ON_RESET`=0, `busy`=0 after reset and a write/read is accepted on the first edge.
6. Non-power-of-two `DEPTH`=6: write 0x5555 at addr 6, then read addr 6 → no memory change; `d_out`=0x0000 with `rd_valid`=1; the sweep lasts 6 edges.
